sram_1k_arbiter: RTL and testbench



---
 rtl/sram_1k_arbiter_pkg.sv | 26 ++
 rtl/sram_1k_arbiter_if.sv | 36 +++
 rtl/sram_strobe_timer.sv | 28 ++
 rtl/sram_1k_arbiter.sv | 127 ++++++++++++
 tb/tb_sram_1k_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1k_arbiter_pkg.sv
// Shared types and constants for the two-requester 1Kx1 SRAM bank arbiter.
package sram_arb_pkg;

  localparam int ADDR_W         = 10;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_WPULSE_CYC = 2;
  localparam int DEF_RPULSE_CYC = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_e;

  // Enough bits to hold the largest phase length, plus one bit of headroom.
  function automatic int cnt_width(input int setup_cyc, input int wpulse_cyc,
                                   input int rpulse_cyc);
    int m;
    m = (setup_cyc > wpulse_cyc) ? setup_cyc : wpulse_cyc;
    m = (m > rpulse_cyc) ? m : rpulse_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sram_1k_arbiter_if.sv
// Requester handshakes and RAM pin bundle for sram_1k_arbiter.
interface sram_1k_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [WIDTH-1:0]  wdata0;
  logic              done0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [WIDTH-1:0]  wdata1;
  logic              done1;
  logic [WIDTH-1:0]  rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_ce_n;
  logic              ram_we_n;
  logic [WIDTH-1:0]  ram_di;
  logic [WIDTH-1:0]  ram_do;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_do,
    output done0, done1, rdata, busy, ram_a, ram_ce_n, ram_we_n, ram_di
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_do,
    input  done0, done1, rdata, busy, ram_a, ram_ce_n, ram_we_n, ram_di
  );

endinterface

// File: rtl/sram_strobe_timer.sv
// Loadable down-counter that parks at zero; times the SETUP and STROBE phases.
module sram_strobe_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_1k_arbiter.sv
// Round-robin arbiter sharing a bank of asynchronous 1Kx1 SRAMs between two
// requesters, with programmable setup / pulse timing and registered pins.
module sram_1k_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int WPULSE_CYC = DEF_WPULSE_CYC,
  parameter int RPULSE_CYC = DEF_RPULSE_CYC
) (
  input logic               clk,
  input logic               reset_n,
  sram_1k_arbiter_if.slave  bus
);

  localparam int CW = cnt_width(SETUP_CYC, WPULSE_CYC, RPULSE_CYC);

  state_e            state_q;
  logic              last_grant_q;
  logic              op_we_q;
  logic [ADDR_W-1:0] ram_a_q;
  logic [WIDTH-1:0]  ram_di_q;
  logic [WIDTH-1:0]  rdata_q;
  logic              ce_n_q;
  logic              we_n_q;
  logic              done0_q;
  logic              done1_q;
  logic              busy_q;

  logic              start_d;
  logic              grant_d;
  logic              tmr_load_d;
  logic [CW-1:0]     tmr_val_d;
  logic              tmr_zero;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    start_d    = 1'b0;
    grant_d    = 1'b0;
    tmr_load_d = 1'b0;
    tmr_val_d  = CW'(SETUP_CYC - 1);
    if (state_q == IDLE && (bus.req0 || bus.req1)) begin
      start_d = 1'b1;
      grant_d = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    end
    if (start_d) begin
      tmr_load_d = 1'b1;
    end else if (state_q == SETUP && tmr_zero) begin
      tmr_load_d = 1'b1;
      tmr_val_d  = op_we_q ? CW'(WPULSE_CYC - 1) : CW'(RPULSE_CYC - 1);
    end
  end

  sram_strobe_timer #(.CNT_W(CW)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .zero_o     (tmr_zero)
  );

  // Address and data move only on the IDLE->SETUP edge, so they are settled a
  // full SETUP phase before the strobe and held through HOLD afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_we_q      <= 1'b0;
      ram_a_q      <= '0;
      ram_di_q     <= '0;
      rdata_q      <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q      <= SETUP;
            busy_q       <= 1'b1;
            last_grant_q <= grant_d;
            op_we_q      <= grant_d ? bus.we1    : bus.we0;
            ram_a_q      <= grant_d ? bus.addr1  : bus.addr0;
            ram_di_q     <= grant_d ? bus.wdata1 : bus.wdata0;
          end
        end
        SETUP: begin
          if (tmr_zero) begin
            state_q <= STROBE;
            ce_n_q  <= 1'b0;
            we_n_q  <= ~op_we_q;
          end
        end
        STROBE: begin
          if (tmr_zero) begin
            state_q <= HOLD;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            if (!op_we_q) rdata_q <= bus.ram_do;
            if (last_grant_q) done1_q <= 1'b1;
            else              done0_q <= 1'b1;
          end
        end
        HOLD: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done0    = done0_q;
  assign bus.done1    = done1_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;
  assign bus.ram_a    = ram_a_q;
  assign bus.ram_ce_n = ce_n_q;
  assign bus.ram_we_n = we_n_q;
  assign bus.ram_di   = ram_di_q;

endmodule

// File: tb/tb_sram_1k_arbiter.sv
// Directed bench: default-timing arbiter plus a 2/1/3 timing instance, each
// wired to a behavioural 1Kx8 RAM bank.
module tb_sram_1k_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sram_1k_arbiter_if #(.WIDTH(8)) ifa ();
  sram_1k_arbiter_if #(.WIDTH(8)) ifb ();

  sram_1k_arbiter #(.WIDTH(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
  );

  sram_1k_arbiter #(.WIDTH(8), .SETUP_CYC(2), .WPULSE_CYC(1), .RPULSE_CYC(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
  );

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];

  always @(posedge clk) if (!ifa.ram_ce_n && !ifa.ram_we_n) mem_a[ifa.ram_a] <= ifa.ram_di;
  always @(posedge clk) if (!ifb.ram_ce_n && !ifb.ram_we_n) mem_b[ifb.ram_a] <= ifb.ram_di;
  assign ifa.ram_do = mem_a[ifa.ram_a];
  assign ifb.ram_do = mem_b[ifb.ram_a];

  function automatic logic [30:0] outs(input bit inst);
    if (inst)
      return {ifb.ram_ce_n, ifb.ram_we_n, ifb.ram_a, ifb.ram_di,
              ifb.done0, ifb.done1, ifb.rdata, ifb.busy};
    return {ifa.ram_ce_n, ifa.ram_we_n, ifa.ram_a, ifa.ram_di,
            ifa.done0, ifa.done1, ifa.rdata, ifa.busy};
  endfunction

  task automatic idle_inputs();
    ifa.req0 = 0; ifa.we0 = 0; ifa.addr0 = '0; ifa.wdata0 = '0;
    ifa.req1 = 0; ifa.we1 = 0; ifa.addr1 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.we0 = 0; ifb.addr0 = '0; ifb.wdata0 = '0;
    ifb.req1 = 0; ifb.we1 = 0; ifb.addr1 = '0; ifb.wdata1 = '0;
  endtask

  // One complete access on instance inst by requester who; returns latency in
  // cycles from the request cycle to done, strobe-low cycles and busy cycles.
  task automatic access(input bit inst, input bit who, input bit we,
                        input logic [9:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int lat,
                        output int low, output int busy_n);
    logic s_ce, s_we, s_busy, s_done;
    logic [9:0] s_a;
    logic [7:0] s_di;
    bit seen, stable, pol, setup_ok;
    seen = 0; stable = 1; pol = 1; setup_ok = 0;
    if (!inst && !who) begin ifa.req0 = 1; ifa.we0 = we; ifa.addr0 = a; ifa.wdata0 = d; end
    if (!inst &&  who) begin ifa.req1 = 1; ifa.we1 = we; ifa.addr1 = a; ifa.wdata1 = d; end
    if ( inst)         begin ifb.req0 = 1; ifb.we0 = we; ifb.addr0 = a; ifb.wdata0 = d; end
    lat = 0; low = 0; busy_n = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      s_ce   = inst ? ifb.ram_ce_n : ifa.ram_ce_n;
      s_we   = inst ? ifb.ram_we_n : ifa.ram_we_n;
      s_busy = inst ? ifb.busy     : ifa.busy;
      s_a    = inst ? ifb.ram_a    : ifa.ram_a;
      s_di   = inst ? ifb.ram_di   : ifa.ram_di;
      s_done = inst ? ifb.done0 : (who ? ifa.done1 : ifa.done0);
      if (lat == 1) setup_ok = (s_ce === 1'b1 && s_we === 1'b1 && s_busy === 1'b1 && s_a === a);
      if (s_a !== a || (we && s_di !== d)) stable = 0;
      if (s_ce === 1'b0) begin
        low++;
        if (s_we !== ~we) pol = 0;
      end else if (s_we !== 1'b1) pol = 0;
      if (s_busy === 1'b1) busy_n++;
      if (s_done === 1'b1) seen = 1;
    end
    rd = inst ? ifb.rdata : ifa.rdata;
    ifa.req0 = 0; ifa.req1 = 0; ifb.req0 = 0;
    checks++; if (!seen)     begin errors++; $display("FAIL done_timeout addr=%h: no done within %0d cycles", a, lat); end
    checks++; if (!setup_ok) begin errors++; $display("FAIL setup_phase addr=%h: first cycle not CE_N=1/WE_N=1/busy with address driven", a); end
    checks++; if (!stable)   begin errors++; $display("FAIL addr_data_stable addr=%h: ram_a/ram_di moved during access", a); end
    checks++; if (!pol)      begin errors++; $display("FAIL strobe_polarity addr=%h: WE_N wrong relative to CE_N (we=%0b)", a, we); end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [30:0] exp_rst;
    exp_rst = {2'b11, 29'd0};
    reset_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (outs(0) !== exp_rst) begin errors++; $display("FAIL reset_a: outputs %h, expected %h", outs(0), exp_rst); end
    checks++; if (outs(1) !== exp_rst) begin errors++; $display("FAIL reset_b: outputs %h, expected %h", outs(1), exp_rst); end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [7:0] rd;
    int lat, low, busy_n;
    access(0, 0, 1, 10'h155, 8'hA5, rd, lat, low, busy_n);
    checks++; if (lat != 4)   begin errors++; $display("FAIL write_latency: got %0d, expected 4", lat); end
    checks++; if (low != 2)   begin errors++; $display("FAIL write_pulse: strobe low %0d cycles, expected 2", low); end
    checks++; if (busy_n != 4) begin errors++; $display("FAIL write_busy: busy %0d cycles, expected 4", busy_n); end
    checks++; if (mem_a[10'h155] !== 8'hA5) begin errors++; $display("FAIL write_data: RAM holds %h, expected a5", mem_a[10'h155]); end
    checks++; if (ifa.done0 !== 1'b0 || ifa.busy !== 1'b0) begin
      errors++; $display("FAIL write_idle_after: done0=%b busy=%b, expected 0 0", ifa.done0, ifa.busy);
    end
  endtask

  task automatic test_read();
    logic [7:0] rd;
    int lat, low, busy_n;
    access(0, 1, 0, 10'h155, 8'h00, rd, lat, low, busy_n);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_data: rdata %h, expected a5", rd); end
    checks++; if (lat != 4)     begin errors++; $display("FAIL read_latency: got %0d, expected 4", lat); end
    checks++; if (low != 2)     begin errors++; $display("FAIL read_pulse: CE_N low %0d cycles, expected 2", low); end
    checks++; if (busy_n != 4)  begin errors++; $display("FAIL read_busy: busy %0d cycles, expected 4", busy_n); end
  endtask

  task automatic test_boundary();
    logic [7:0] rd;
    int lat, low, busy_n;
    access(0, 0, 1, 10'h3FF, 8'hFF, rd, lat, low, busy_n);
    access(0, 1, 1, 10'h000, 8'h00, rd, lat, low, busy_n);
    access(0, 1, 0, 10'h3FF, 8'h00, rd, lat, low, busy_n);
    checks++; if (rd !== 8'hFF) begin errors++; $display("FAIL boundary_3ff: rdata %h, expected ff", rd); end
    access(0, 0, 0, 10'h000, 8'h00, rd, lat, low, busy_n);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL boundary_000: rdata %h, expected 00", rd); end
  endtask

  task automatic test_contention();
    bit order [4];
    int t [4];
    int n;
    reset_n = 0;
    @(negedge clk);
    ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 10'h010; ifa.wdata0 = 8'h11;
    ifa.req1 = 1; ifa.we1 = 1; ifa.addr1 = 10'h020; ifa.wdata1 = 8'h22;
    reset_n = 1;
    n = 0;
    for (int cyc = 1; cyc <= 40 && n < 4; cyc++) begin
      @(negedge clk);
      if (ifa.done0 === 1'b1 || ifa.done1 === 1'b1) begin
        order[n] = ifa.done1;
        t[n] = cyc;
        n++;
      end
    end
    ifa.req0 = 0; ifa.req1 = 0;
    repeat (2) @(negedge clk);
    checks++; if (n != 4) begin errors++; $display("FAIL contention_count: %0d dones, expected 4", n); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (order[k] != k[0]) begin errors++; $display("FAIL contention_order[%0d]: grant %0d, expected %0d", k, order[k], k[0]); end
      end
      checks++; if (t[0] != 4) begin errors++; $display("FAIL contention_first: done at cycle %0d, expected 4", t[0]); end
      for (int k = 1; k < 4; k++) begin
        checks++; if (t[k] - t[k-1] != 5) begin errors++; $display("FAIL contention_gap[%0d]: %0d cycles, expected 5", k, t[k] - t[k-1]); end
      end
    end
    checks++; if (mem_a[10'h010] !== 8'h11 || mem_a[10'h020] !== 8'h22) begin
      errors++; $display("FAIL contention_data: RAM %h/%h, expected 11/22", mem_a[10'h010], mem_a[10'h020]);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [30:0] exp_rst;
    bit found, saw_done;
    exp_rst = {2'b11, 29'd0};
    found = 0; saw_done = 0;
    ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 10'h0AA; ifa.wdata0 = 8'h3C;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ifa.ram_ce_n === 1'b0) found = 1;
    end
    checks++; if (!found || ifa.ram_we_n !== 1'b0) begin
      errors++; $display("FAIL midreset_strobe: strobe seen=%0b we_n=%b, expected 1 0", found, ifa.ram_we_n);
    end
    reset_n = 0;
    #1;
    checks++; if (outs(0) !== exp_rst) begin errors++; $display("FAIL midreset_outputs: outputs %h, expected %h", outs(0), exp_rst); end
    @(negedge clk);
    ifa.req0 = 0;
    reset_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (ifa.done0 === 1'b1 || ifa.done1 === 1'b1) saw_done = 1;
    end
    checks++; if (saw_done || ifa.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_done: done seen=%0b busy=%b, expected 0 0", saw_done, ifa.busy);
    end
  endtask

  task automatic test_timing();
    logic [7:0] rd;
    int lat, low, busy_n;
    access(1, 0, 1, 10'h2AA, 8'h5A, rd, lat, low, busy_n);
    checks++; if (lat != 4)    begin errors++; $display("FAIL timing_write_latency: got %0d, expected 4", lat); end
    checks++; if (low != 1)    begin errors++; $display("FAIL timing_write_pulse: %0d cycles, expected 1", low); end
    access(1, 0, 0, 10'h2AA, 8'h00, rd, lat, low, busy_n);
    checks++; if (lat != 6)    begin errors++; $display("FAIL timing_read_latency: got %0d, expected 6", lat); end
    checks++; if (low != 3)    begin errors++; $display("FAIL timing_read_pulse: %0d cycles, expected 3", low); end
    checks++; if (busy_n != 6) begin errors++; $display("FAIL timing_read_busy: %0d cycles, expected 6", busy_n); end
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL timing_read_data: rdata %h, expected 5a", rd); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_boundary();
    test_contention();
    test_reset_mid_write();
    test_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
